// File: rtl/spi_slave_rx.sv
// spi_slave_rx: 4-wire SPI receiver that tags each byte with D/C and queues {dc, byte} words in a FWFT FIFO.
// Ports:
//   clk, rst            system clock (>= 4x SCK) and asynchronous active-high reset
//   spi_sck, spi_mosi   serial clock and MSB-first serial data
//   spi_dc, spi_cs      data/command flag and active-low chip select
//   rd_en, rd_data      pop strobe and FIFO head word {dc, byte}
//   rd_valid            FIFO not empty
//   fifo_level          number of queued words
//   clr_overflow        clears the sticky overflow flag
//   overflow            sticky: a word was dropped on a full FIFO
//   frame_error         one-cycle pulse when CS rises mid-byte
//   busy                CS asserted or a partial byte is held
module spi_slave_rx #(
    parameter int DATA_SIZE   = 9,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            spi_sck,
    input  logic                            spi_mosi,
    input  logic                            spi_dc,
    input  logic                            spi_cs,
    input  logic                            rd_en,
    input  logic                            clr_overflow,
    output logic [DATA_SIZE-1:0]            rd_data,
    output logic                            rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
    output logic                            frame_error,
    output logic                            busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sck_sr, mosi_sr, dc_sr, cs_sr;
    logic                   sck_s, mosi_s, dc_s, cs_s, sck_d, sck_rise;
    logic                   shift_en, byte_done, abort;
    logic [2:0]             cnt;
    logic [6:0]             shift;
    logic                   push_q;
    logic [DATA_SIZE-1:0]   word_q, last_q;
    logic [DATA_SIZE-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [LW-1:0]          level;
    logic                   pop, full, wr;

    // All four pins go through the same depth so mosi/dc stay aligned with sck.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sck_sr  <= '0;
            mosi_sr <= '0;
            dc_sr   <= '0;
            cs_sr   <= '1;
            sck_d   <= 1'b0;
        end else begin
            sck_sr  <= {sck_sr[SYNC_STAGES-2:0], spi_sck};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
            dc_sr   <= {dc_sr[SYNC_STAGES-2:0], spi_dc};
            cs_sr   <= {cs_sr[SYNC_STAGES-2:0], spi_cs};
            sck_d   <= sck_s;
        end

    assign sck_s    = sck_sr[SYNC_STAGES-1];
    assign mosi_s   = mosi_sr[SYNC_STAGES-1];
    assign dc_s     = dc_sr[SYNC_STAGES-1];
    assign cs_s     = cs_sr[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    always_comb state_nx = cs_s ? IDLE : SHIFT;

    // Shifting keys off CS rather than state so a rise in the first CS-low cycle is not lost.
    always_comb begin
        shift_en  = ~cs_s & sck_rise;
        byte_done = shift_en & (cnt == 3'd7);
        abort     = (state == SHIFT) & cs_s & (cnt != 3'd0);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt         <= '0;
            shift       <= '0;
            push_q      <= 1'b0;
            word_q      <= '0;
            frame_error <= 1'b0;
        end else begin
            cnt         <= cs_s ? 3'd0 : shift_en ? cnt + 3'd1 : cnt;
            if (shift_en) shift <= {shift[5:0], mosi_s};
            push_q      <= byte_done;
            if (byte_done) word_q <= DATA_SIZE'({dc_s, shift, mosi_s});
            frame_error <= abort;
        end

    assign busy = ~cs_s | (cnt != 3'd0);

    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign pop  = rd_en & (level != '0);
    assign full = level == LW'(FIFO_DEPTH);
    assign wr   = push_q & (~full | pop);

    always_ff @(posedge clk)
        if (wr) mem[wr_ptr] <= word_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            last_q   <= '0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(wr);
            rd_ptr   <= rd_ptr + AW'(pop);
            level    <= level + LW'(wr) - LW'(pop);
            overflow <= (push_q & ~wr) ? 1'b1 : clr_overflow ? 1'b0 : overflow;
            if (pop) last_q <= mem[rd_ptr];
        end

    assign rd_valid   = level != '0;
    assign fifo_level = level;
    assign rd_data    = rd_valid ? mem[rd_ptr] : last_q;
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: directed bench for spi_slave_rx with an SCK = clk/8 bit-banged master.
module tb_spi_slave_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_sck = 1'b0, spi_mosi = 1'b0, spi_dc = 1'b0, spi_cs = 1'b1;
    logic       rd_en = 1'b0, clr_overflow = 1'b0;
    logic [8:0] rd_data;
    logic       rd_valid, overflow, frame_error, busy;
    logic [2:0] fifo_level;
    int         total = 0, bad = 0, fe_cnt = 0, fe_mark;
    logic [8:0] w;
    logic [8:0] exp_q [4];

    spi_slave_rx dut (
        .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_dc(spi_dc),
        .spi_cs(spi_cs), .rd_en(rd_en), .clr_overflow(clr_overflow), .rd_data(rd_data),
        .rd_valid(rd_valid), .fifo_level(fifo_level), .overflow(overflow),
        .frame_error(frame_error), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_error) fe_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bits are driven MSB first; pop_last raises rd_en on the cycle the 8th bit is pushed.
    task automatic send_byte(input logic dc, input logic [7:0] b, input int nbits, input logic pop_last);
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = b[i];
            spi_dc   = dc;
            repeat (4) @(negedge clk);
            spi_sck = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (pop_last && i == 0 && k == 3) rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
            end
            spi_sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clk);
        spi_cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", rd_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_fe", frame_error, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", rd_data, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        fe_mark = fe_cnt;
        cs_low();
        chk("busy_cs", busy, 1);
        send_byte(1'b0, 8'h2A, 8, 1'b0);
        cs_high();
        chk("single_level", fifo_level, 1);
        chk("single_valid", rd_valid, 1);
        chk("single_data", rd_data, 9'h02A);
        chk("single_fe", fe_cnt - fe_mark, 0);
        chk("single_busy", busy, 0);
        pop();
        chk("single_empty", fifo_level, 0);
        chk("single_hold", rd_data, 9'h02A);
        pop();
        chk("empty_pop_level", fifo_level, 0);
        chk("empty_pop_hold", rd_data, 9'h02A);

        exp_q = '{9'h100, 9'h1FF, 9'h1A5, 9'h000};
        cs_low();
        send_byte(1'b1, 8'h00, 8, 1'b0);
        send_byte(1'b1, 8'hFF, 8, 1'b0);
        send_byte(1'b1, 8'hA5, 8, 1'b0);
        cs_high();
        chk("b2b_level", fifo_level, 3);
        for (int i = 0; i < 3; i++) begin
            chk("b2b_data", rd_data, exp_q[i]);
            pop();
            chk("b2b_level_step", fifo_level, 2 - i);
        end

        fe_mark = fe_cnt;
        cs_low();
        send_byte(1'b0, 8'hF0, 5, 1'b0);
        chk("abort_busy_mid", busy, 1);
        repeat (4) @(negedge clk);
        spi_cs = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_fe_pulses", fe_cnt - fe_mark, 1);
        chk("abort_level", fifo_level, 0);
        chk("abort_busy", busy, 0);
        cs_low();
        send_byte(1'b0, 8'h3C, 8, 1'b0);
        cs_high();
        chk("after_abort_level", fifo_level, 1);
        chk("after_abort_data", rd_data, 9'h03C);
        pop();

        cs_low();
        for (int i = 0; i < 5; i++) send_byte(1'b0, 8'(8'h10 + i), 8, 1'b0);
        cs_high();
        chk("ovf_level", fifo_level, 4);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", rd_data, 9'h010);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        chk("ovf_clr", overflow, 0);
        cs_low();
        send_byte(1'b0, 8'h15, 8, 1'b1);
        cs_high();
        chk("full_pp_level", fifo_level, 4);
        chk("full_pp_ovf", overflow, 0);
        exp_q = '{9'h011, 9'h012, 9'h013, 9'h015};
        for (int i = 0; i < 4; i++) begin
            chk("full_pp_data", rd_data, exp_q[i]);
            pop();
        end
        chk("full_pp_drained", rd_valid, 0);

        fe_mark = fe_cnt;
        cs_low();
        for (int i = 0; i < 16; i++) begin
            w = 9'($urandom);
            send_byte(w[8], w[7:0], 8, 1'b0);
            repeat (2) @(negedge clk);
            chk("stream_level", fifo_level, 1);
            chk("stream_data", rd_data, w);
            pop();
        end
        cs_high();
        chk("stream_fe", fe_cnt - fe_mark, 0);
        chk("stream_empty", fifo_level, 0);

        fe_mark = fe_cnt;
        cs_low();
        send_byte(1'b1, 8'hE0, 3, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_valid", rd_valid, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data", rd_data, 0);
        chk("mid_rst_ovf", overflow, 0);
        rst = 1'b0;
        spi_cs = 1'b1;
        repeat (8) @(negedge clk);
        cs_low();
        send_byte(1'b1, 8'h81, 8, 1'b0);
        cs_high();
        chk("post_rst_level", fifo_level, 1);
        chk("post_rst_data", rd_data, 9'h181);
        chk("post_rst_fe", fe_cnt - fe_mark, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
